// File: rtl/alu_share_if.sv
// Requester-side bundle for alu_share_ctrl: two request/operand ports and the shared result.
interface alu_share_if;
    logic               req_a;
    logic               req_b;
    logic [2:0]         opc_a;
    logic [2:0]         opc_b;
    logic signed [15:0] ina_a;
    logic signed [15:0] inb_a;
    logic signed [15:0] ina_b;
    logic signed [15:0] inb_b;
    logic               inc_a;
    logic               inc_b;
    logic               gnt_a;
    logic               gnt_b;
    logic               done_a;
    logic               done_b;
    logic signed [15:0] w;
    logic               zer;
    logic               neg;
    logic               busy;

    modport slave (
        input  req_a, req_b, opc_a, opc_b, ina_a, inb_a, ina_b, inb_b, inc_a, inc_b,
        output gnt_a, gnt_b, done_a, done_b, w, zer, neg, busy
    );

    modport master (
        output req_a, req_b, opc_a, opc_b, ina_a, inb_a, ina_b, inb_b, inc_a, inc_b,
        input  gnt_a, gnt_b, done_a, done_b, w, zer, neg, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller time-sharing one 16-bit adder/logic datapath between ports A and B.
// Define ALU_SHARE_MUL_EN to enable opcode 111 as a 16-iteration shift-add multiply.
module alu_share_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    alu_share_if.slave io_bus
);
    localparam int DATA_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
`ifdef ALU_SHARE_MUL_EN
    localparam logic [1:0] S_MULT = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]               r_state;
    logic                     r_last_b;
    logic                     r_id_b;
    logic                     r_gnt_a;
    logic                     r_gnt_b;
    logic                     r_done_a;
    logic                     r_done_b;
    logic [DATA_W-1:0]        r_w;
    logic                     r_zer;
    logic                     r_neg;
    logic [2:0]               r_opc;
    logic signed [DATA_W-1:0] r_a;
    logic signed [DATA_W-1:0] r_b;
    logic                     r_c;
`ifdef ALU_SHARE_MUL_EN
    logic [DATA_W-1:0]        r_acc;
    logic [3:0]               r_cnt;
`endif

    logic                     w_any;
    logic                     w_win_b;
    logic                     w_add_c;
    logic [DATA_W-1:0]        w_add_x;
    logic [DATA_W-1:0]        w_add_y;
    logic [DATA_W-1:0]        w_sum;
    logic [DATA_W-1:0]        w_res;

    // Non-adder ops bypass the shared sum; 111 without multiply support yields zero.
    function automatic logic [DATA_W-1:0] f_result(
        input logic [2:0]        opc,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] sum
    );
        case (opc)
            3'b100:  f_result = a & b;
            3'b101:  f_result = a | b;
            3'b110:  f_result = {a[7:0], b[7:0]};
            3'b111:  f_result = '0;
            default: f_result = sum;
        endcase
    endfunction

    assign w_any   = io_bus.req_a | io_bus.req_b;
    assign w_win_b = (io_bus.req_a & io_bus.req_b) ? ~r_last_b : io_bus.req_b;

    always_comb begin
        w_add_x = r_a;
        w_add_y = '0;
        w_add_c = 1'b0;
        case (r_opc)
            3'b000: begin
                w_add_x = ~r_a;
                w_add_c = 1'b1;
            end
            3'b001: w_add_c = 1'b1;
            3'b010: begin
                w_add_y = r_b;
                w_add_c = r_c;
            end
            3'b011: w_add_y = r_b >>> 1;
            default: ;
        endcase
`ifdef ALU_SHARE_MUL_EN
        // During MULT the same adder accumulates the shifted partial products.
        if (r_state == S_MULT) begin
            w_add_x = r_acc;
            w_add_y = r_b[r_cnt] ? (r_a << r_cnt) : '0;
            w_add_c = 1'b0;
        end
`endif
    end

    assign w_sum = w_add_x + w_add_y + {{(DATA_W-1){1'b0}}, w_add_c};
    assign w_res = f_result(r_opc, r_a, r_b, w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last_b <= 1'b1;
            r_id_b   <= 1'b0;
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_w      <= '0;
            r_zer    <= 1'b0;
            r_neg    <= 1'b0;
`ifdef ALU_SHARE_MUL_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_a  <= ~w_win_b;
                        r_gnt_b  <= w_win_b;
                        r_id_b   <= w_win_b;
                        r_last_b <= w_win_b;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef ALU_SHARE_MUL_EN
                    if (r_opc == 3'b111) begin
                        r_cnt   <= '0;
                        r_state <= S_MULT;
                    end else
`endif
                    begin
                        r_w      <= w_res;
                        r_zer    <= (w_res == '0);
                        r_neg    <= w_res[DATA_W-1];
                        r_done_a <= ~r_id_b;
                        r_done_b <= r_id_b;
                        r_state  <= S_DONE;
                    end
                end
`ifdef ALU_SHARE_MUL_EN
                S_MULT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_w      <= w_sum;
                        r_zer    <= (w_sum == '0);
                        r_neg    <= w_sum[DATA_W-1];
                        r_done_a <= ~r_id_b;
                        r_done_b <= r_id_b;
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand capture carries no reset: it is only consumed after a grant loads it.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any) begin
            r_opc <= w_win_b ? io_bus.opc_b : io_bus.opc_a;
            r_a   <= w_win_b ? io_bus.ina_b : io_bus.ina_a;
            r_b   <= w_win_b ? io_bus.inb_b : io_bus.inb_a;
            r_c   <= w_win_b ? io_bus.inc_b : io_bus.inc_a;
        end
`ifdef ALU_SHARE_MUL_EN
        if (r_state == S_EXEC) begin
            r_acc <= '0;
        end else if (r_state == S_MULT) begin
            r_acc <= w_sum;
        end
`endif
    end

    assign io_bus.gnt_a  = r_gnt_a;
    assign io_bus.gnt_b  = r_gnt_b;
    assign io_bus.done_a = r_done_a;
    assign io_bus.done_b = r_done_b;
    assign io_bus.w      = r_w;
    assign io_bus.zer    = r_zer;
    assign io_bus.neg    = r_neg;
    assign io_bus.busy   = (r_state != S_IDLE);
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that time-shares one 16-bit ALU datapath between ports A and B. It arbitrates requests round-robin, captures the winner's operands, and sequences execution. Single-cycle ops complete in one execute cycle; an optional multiply takes 16 shift-add iterations through the same adder. The block sits between requesting units and the ALU, returning a registered result with zero and negative flags.

## Interface
- No parameters; data width fixed at 16, opcode width 3.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_a / req_b  in  1  request; held high until the matching gnt
- opc_a / opc_b  in  3  opcode
- ina_a, inb_a / ina_b, inb_b  in  16  signed operands
- inc_a / inc_b  in  1  carry-in, used by opcode 010 only
- gnt_a / gnt_b  out  1  one-cycle pulse; operands have been captured
- done_a / done_b  out  1  one-cycle pulse; w/zer/neg are valid
- w  out  16  registered result; holds until the next done
- zer  out  1  registered; 1 when w == 0
- neg  out  1  registered; equals w[15]
- busy  out  1  high in every state except IDLE

## Operation
- Op table (captured a, b, c):
  - 000: ~a+1
  - 001: a+1
  - 010: a+b+c
  - 011: a+(b>>>1), arithmetic shift
  - 100: a&b
  - 101: a|b
  - 110: {a[7:0],b[7:0]}
  - 111: MUL, or 0 (see Configuration)
- All arithmetic is modulo 2^16; carry-out is discarded.
- FSM states:
  - IDLE: if any req is high, select a winner, capture opc/ina/inb/inc and the requester id, pulse its gnt, go to EXEC. Otherwise stay in IDLE.
  - EXEC: for opcodes 000-110, register w/zer/neg and go to DONE. For MUL, clear the accumulator and counter and go to MULT.
  - MULT: each cycle, if b[cnt] is 1, acc = acc + (a<<cnt) via the op-010 adder with c=0. Increment cnt. After the cnt=15 iteration, register w=acc with its flags and go to DONE.
  - DONE: pulse done for the captured requester, then go to IDLE.
- Arbitration:
  - Round-robin pointer records the last-served requester.
  - On simultaneous requests, the requester not last served wins.
  - Pointer resets to "B last served", so A wins the first tie.
  - A lone requester always wins, regardless of the pointer.
- Requests are sampled only in IDLE. A req still high in IDLE after its done counts as a new request.
- Input changes after gnt have no effect; operands are latched.
- Opcode 111 with MUL disabled behaves as a single-cycle op with w=0, zer=1, neg=0.

## Timing
- Reset values: w=0, zer=0, neg=0, gnt_a/b=0, done_a/b=0, busy=0, state=IDLE, pointer=B, counter=0.
- rst_n low at any time (including mid-MULT) aborts the op with no done, and all outputs take their reset values immediately.
- Let G be the cycle in which gnt is high (the first EXEC cycle):
  - Single-cycle op: done and the new w appear in cycle G+1. IDLE is at G+2, and the next capture happens at the end of G+2.
  - Back-to-back throughput: one single-cycle op every 3 cycles.
  - MUL: done in cycle G+17; w updates in the same cycle.
- gnt and done are registered outputs, high for exactly one cycle, and never both high for the same requester.
- busy rises in cycle G and falls in the first cycle after done.
- zer and neg always describe the current w.

## Configuration
- Macro ALU_SHARE_MUL_EN.
- Defined: opcode 111 = low 16 bits of a*b via the MULT state (16 iterations).
- Undefined: the MULT state and counter are not compiled in, and opcode 111 returns w=0 in one cycle.

## Test plan
- Reset, then A requests opc 000, ina=0005 -> gnt_a in G, done_a in G+1, w=FFFB, neg=1, zer=0.
- B requests opc 010, ina=7FFF, inb=0001, inc=0 -> w=8000, neg=1. Repeat with inc=1 and inb=FFFF -> w=7FFF.
- A requests opc 011 (a=0010, b=FFF0) -> w=0008. Then opc 110 (a=1234, b=ABCD) -> w=34CD.
- A and B both hold req continuously with different ops:
  - First tie: A served.
  - Then B, then A, in alternation.
  - Each done appears on the correct port.
- MUL_EN defined:
  - opc 111, a=0003, b=0005 -> w=000F, done_a exactly 17 cycles after gnt_a.
  - a=0100, b=0100 -> w=0000, zer=1.
  - MUL_EN undefined: same stimulus -> w=0, done in G+1.
- Assert rst_n in the 8th MULT cycle -> no done, all outputs at reset values. Next tie goes to A.
